// File: rtl/cla_add_pipe_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
// Group width is fixed at 4; the legal operand width range is checked at elaboration.
package cla_add_pipe_pkg;

  localparam int GRP_W = 4;
  localparam int MAX_W = 64;

  typedef struct packed {
    logic c_out;
    logic ovf;
  } flags_t;

  function automatic int ngrp(input int w);
    return w / GRP_W;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= GRP_W) && (w <= MAX_W) && ((w % GRP_W) == 0);
  endfunction

endpackage

// File: rtl/cla_add_pipe_if.sv
// Operand-in / result-out handshake bundle for cla_add_pipe.
// The master side drives operands and out_ready; the slave side is the adder.
interface cla_add_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, x, y, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, x, y, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/cla_group4.sv
// Combinational 4-bit lookahead group: carries c[4:1] from ci plus group generate/propagate.
// Reused both for bit-level carries inside a group and for carries across groups.
module cla_group4
  import cla_add_pipe_pkg::*;
(
  input  logic [GRP_W-1:0] p,
  input  logic [GRP_W-1:0] g,
  input  logic             ci,
  output logic [GRP_W:1]   c,
  output logic             grp_g,
  output logic             grp_p
);

  assign c[1]  = g[0] | (p[0] & ci);
  assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;
  assign c[4]  = grp_g | (grp_p & ci);

endmodule

// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with ready/valid on both sides.
// Stage A registers bit and group generate/propagate; stage B registers the finished sum.
module cla_add_pipe
  import cla_add_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  cla_add_pipe_if.slave bus
);

  localparam int NGRP = ngrp(WIDTH);
  localparam int NSUP = (NGRP + 3) / 4;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("cla_add_pipe: WIDTH=%0d must be a multiple of %0d in %0d..%0d", WIDTH, GRP_W, GRP_W, MAX_W);
  end

  logic vld_a, vld_b, adv_a, adv_b, accept;

  assign adv_b        = ~vld_b | bus.out_ready;
  assign adv_a        = ~vld_a | adv_b;
  assign accept       = bus.in_valid & adv_a;
  assign bus.in_ready = adv_a;

  // Subtraction is x + ~y + ~borrow, so borrow-in becomes an inverted carry-in.
  logic [WIDTH-1:0] y_e, p_in, g_in;
  logic             c0_in;
  logic [NGRP-1:0]  gg_in, pp_in;

  assign y_e   = bus.sub ? ~bus.y : bus.y;
  assign c0_in = bus.sub ? ~bus.c_in : bus.c_in;
  assign p_in  = bus.x ^ y_e;
  assign g_in  = bus.x & y_e;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp_a
    logic [GRP_W:1] unused_c;
    cla_group4 u_grp (
      .p(p_in[k*GRP_W +: GRP_W]), .g(g_in[k*GRP_W +: GRP_W]), .ci(1'b0),
      .c(unused_c), .grp_g(gg_in[k]), .grp_p(pp_in[k])
    );
  end

  logic [WIDTH-1:0] p_a, g_a;
  logic             c0_a;
  logic [NGRP-1:0]  gg_a, pp_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a <= 1'b0;
      p_a   <= '0;
      g_a   <= '0;
      c0_a  <= 1'b0;
      gg_a  <= '0;
      pp_a  <= '0;
    end else begin
      if (adv_a) vld_a <= bus.in_valid;
      if (accept) begin
        p_a  <= p_in;
        g_a  <= g_in;
        c0_a <= c0_in;
        gg_a <= gg_in;
        pp_a <= pp_in;
      end
    end
  end

  // Group G/P padded to whole blocks of four; pad groups only feed carries above the MSB.
  logic [4*NSUP-1:0] gg_pad, pp_pad;
  logic [4*NSUP:0]   cg;

  always_comb begin
    gg_pad           = '0;
    pp_pad           = '0;
    gg_pad[NGRP-1:0] = gg_a;
    pp_pad[NGRP-1:0] = pp_a;
  end

  assign cg[0] = c0_a;

  if (NSUP == 1) begin : g_flat
    logic unused_g, unused_p;
    cla_group4 u_la (
      .p(pp_pad), .g(gg_pad), .ci(c0_a),
      .c(cg[4:1]), .grp_g(unused_g), .grp_p(unused_p)
    );
  end else begin : g_tree
    logic [NSUP-1:0] sg_raw, sp_raw;
    logic [3:0]      sg, sp;
    logic [4:0]      sc;
    logic            unused_g, unused_p, unused_sc;

    assign sc[0] = c0_a;

    for (genvar j = 0; j < NSUP; j++) begin : g_blk
      cla_group4 u_blk (
        .p(pp_pad[4*j +: 4]), .g(gg_pad[4*j +: 4]), .ci(sc[j]),
        .c(cg[4*j+1 +: 4]), .grp_g(sg_raw[j]), .grp_p(sp_raw[j])
      );
    end

    always_comb begin
      sg             = '0;
      sp             = '0;
      sg[NSUP-1:0]   = sg_raw;
      sp[NSUP-1:0]   = sp_raw;
    end

    cla_group4 u_top (
      .p(sp), .g(sg), .ci(c0_a),
      .c(sc[4:1]), .grp_g(unused_g), .grp_p(unused_p)
    );
    assign unused_sc = ^sc[4:1];
  end

  logic unused_cg;
  assign unused_cg = ^cg[4*NSUP:NGRP];

  logic [WIDTH:0] c_int;
  assign c_int[0] = c0_a;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp_b
    logic unused_g, unused_p;
    cla_group4 u_grp (
      .p(p_a[k*GRP_W +: GRP_W]), .g(g_a[k*GRP_W +: GRP_W]), .ci(cg[k]),
      .c(c_int[k*GRP_W+1 +: GRP_W]), .grp_g(unused_g), .grp_p(unused_p)
    );
  end

  logic [WIDTH-1:0] s_b;
  flags_t           flags_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_b   <= 1'b0;
      s_b     <= '0;
      flags_b <= '0;
    end else begin
      if (adv_b) vld_b <= vld_a;
      if (vld_a && adv_b) begin
        s_b           <= p_a ^ c_int[WIDTH-1:0];
        flags_b.c_out <= c_int[WIDTH];
        flags_b.ovf   <= c_int[WIDTH] ^ c_int[WIDTH-1];
      end
    end
  end

  assign bus.out_valid = vld_b;
  assign bus.s         = s_b;
  assign bus.c_out     = flags_b.c_out;
  assign bus.ovf       = flags_b.ovf;

endmodule

// File: tb/tb_cla_add_pipe.sv
// Bench for cla_add_pipe: four widths driven in lockstep against an arithmetic reference
// model and a queue-based model of the two-deep ready/valid pipeline.
module tb_cla_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, c_in, sub;
  logic [63:0] x, y;

  always #5 clk = ~clk;

  cla_add_pipe_if #(.WIDTH(4))  b4 ();
  cla_add_pipe_if #(.WIDTH(16)) b16 ();
  cla_add_pipe_if #(.WIDTH(32)) b32 ();
  cla_add_pipe_if #(.WIDTH(64)) b64 ();

  assign b4.in_valid  = in_valid;  assign b4.out_ready  = out_ready;  assign b4.c_in  = c_in;  assign b4.sub  = sub;
  assign b4.x         = x[3:0];    assign b4.y          = y[3:0];
  assign b16.in_valid = in_valid;  assign b16.out_ready = out_ready;  assign b16.c_in = c_in;  assign b16.sub = sub;
  assign b16.x        = x[15:0];   assign b16.y         = y[15:0];
  assign b32.in_valid = in_valid;  assign b32.out_ready = out_ready;  assign b32.c_in = c_in;  assign b32.sub = sub;
  assign b32.x        = x[31:0];   assign b32.y         = y[31:0];
  assign b64.in_valid = in_valid;  assign b64.out_ready = out_ready;  assign b64.c_in = c_in;  assign b64.sub = sub;
  assign b64.x        = x;         assign b64.y         = y;

  cla_add_pipe #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  cla_add_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  cla_add_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  cla_add_pipe #(.WIDTH(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic        ci;
    logic        sb;
    int          a;
  } beat_t;

  beat_t       q[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          t        = 0;
  int          n_pop    = 0;
  int          pop_t    = 0;
  logic        last_acc = 1'b0;
  logic        last_pop = 1'b0;
  logic        chk_lat  = 1'b0;
  logic [65:0] last_res = '0;

  task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // {ovf, c_out, s} from plain integer arithmetic on w-bit operands.
  function automatic logic [65:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic ci, input logic sb, input int w);
    logic signed [71:0] ua, ub, ur, sa, sbv, sr, lim, cs, two_w;
    logic [63:0]        mask;
    logic               co, ov;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    cs    = 72'(ci);
    two_w = 72'sd1 <<< w;
    ua    = 72'(a & mask);
    ub    = 72'(b & mask);
    ur    = sb ? (ua - ub - cs) : (ua + ub + cs);
    co    = sb ? (ur >= 0) : (ur >= two_w);
    sa    = a[w-1] ? (ua - two_w) : ua;
    sbv   = b[w-1] ? (ub - two_w) : ub;
    sr    = sb ? (sa - sbv - cs) : (sa + sbv + cs);
    lim   = 72'sd1 <<< (w - 1);
    ov    = (sr >= lim) || (sr < -lim);
    return {ov, co, ur[63:0] & mask};
  endfunction

  // One clock: entered just after a negedge with inputs driven, returns at the next negedge.
  task automatic cycle();
    int   e;
    logic ir, ov;
    #1;
    e  = t + 1;
    ir = (q.size() < 2) || out_ready;
    ov = (q.size() > 0) && (e - q[0].a >= 2);
    chk("in_ready", 66'({b4.in_ready, b16.in_ready, b32.in_ready, b64.in_ready}), 66'({4{ir}}));
    chk("out_valid", 66'({b4.out_valid, b16.out_valid, b32.out_valid, b64.out_valid}), 66'({4{ov}}));
    if (ov) begin
      chk("res_w4",  {b4.ovf,  b4.c_out,  64'(b4.s)},  ref_op(q[0].x, q[0].y, q[0].ci, q[0].sb, 4));
      chk("res_w16", {b16.ovf, b16.c_out, 64'(b16.s)}, ref_op(q[0].x, q[0].y, q[0].ci, q[0].sb, 16));
      chk("res_w32", {b32.ovf, b32.c_out, 64'(b32.s)}, ref_op(q[0].x, q[0].y, q[0].ci, q[0].sb, 32));
      chk("res_w64", {b64.ovf, b64.c_out, b64.s},      ref_op(q[0].x, q[0].y, q[0].ci, q[0].sb, 64));
      last_res = {b32.ovf, b32.c_out, 64'(b32.s)};
    end
    last_acc = in_valid && ir;
    last_pop = ov && out_ready;
    @(posedge clk);
    t = e;
    if (last_pop) begin
      if (chk_lat) chk("latency", 66'(t - q[0].a), 66'(2));
      pop_t = t;
      n_pop++;
      void'(q.pop_front());
    end
    if (last_acc) q.push_back('{x: x, y: y, ci: c_in, sb: sub, a: t});
    @(negedge clk);
  endtask

  task automatic send_one(input logic [63:0] xa, input logic [63:0] ya, input logic ci, input logic sb);
    int n0, k;
    n0 = n_pop;
    x = xa; y = ya; c_in = ci; sub = sb;
    in_valid = 1'b1; out_ready = 1'b1; chk_lat = 1'b1;
    cycle();
    in_valid = 1'b0;
    k = 0;
    while (n_pop == n0 && k < 10) begin
      cycle();
      k++;
    end
    chk("drain", 66'(n_pop - n0), 66'(1));
    chk_lat = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, acc, n0, first_p, last_p, guard;
    logic [63:0] bx[4];
    logic [63:0] by[4];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 66'({b4.out_valid, b16.out_valid, b32.out_valid, b64.out_valid}), 66'(0));
    chk("rst_in_ready",  66'({b4.in_ready, b16.in_ready, b32.in_ready, b64.in_ready}), 66'(4'hF));
    chk("rst_res32", {b32.ovf, b32.c_out, 64'(b32.s)}, 66'(0));
    chk("rst_res64", {b64.ovf, b64.c_out, b64.s}, 66'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // reset with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1;
    x = 64'd3;  y = 64'd4;  cycle();
    x = 64'd10; y = 64'd20; cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_valid", 66'({b4.out_valid, b16.out_valid, b32.out_valid, b64.out_valid}), 66'(0));
    chk("t1_rst_s", {2'b00, 64'(b32.s)}, 66'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("t1_in_ready", 66'(b32.in_ready), 66'(1));
    @(negedge clk);
    repeat (4) cycle();

    // directed carries, borrows and overflow
    send_one(64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk("t2_ripple", last_res, {1'b0, 1'b1, 64'h0});
    send_one(64'd5, 64'd7, 1'b0, 1'b1);
    chk("t3_sub_neg", last_res, {1'b0, 1'b0, 64'hFFFF_FFFE});
    send_one(64'h8000_0000, 64'd1, 1'b0, 1'b1);
    chk("t3_sub_ovf", last_res, {1'b1, 1'b1, 64'h7FFF_FFFF});
    send_one(64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk("t3_add_ovf", last_res, {1'b1, 1'b0, 64'h8000_0000});
    send_one(64'd1, 64'd1, 1'b1, 1'b0);
    chk("t3_add_cin", last_res, {1'b0, 1'b0, 64'h3});
    send_one(64'd5, 64'd2, 1'b1, 1'b1);
    chk("t3_sub_bin", last_res, {1'b0, 1'b1, 64'h2});

    // backpressure: four beats, downstream stalled for six cycles
    for (int i = 0; i < 4; i++) begin
      bx[i] = {$urandom, $urandom};
      by[i] = {$urandom, $urandom};
    end
    out_ready = 1'b0; k = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (k < 4);
      if (k < 4) begin x = bx[k]; y = by[k]; c_in = 1'b0; sub = 1'b0; end
      cycle();
      if (last_acc) k++;
      if (i >= 2) chk("t4_hold", 66'(b32.s), 66'(ref_op(bx[0], by[0], 1'b0, 1'b0, 32) & 66'hFFFF_FFFF));
    end
    chk("t4_accepts", 66'(k), 66'(2));
    out_ready = 1'b1; n0 = n_pop; first_p = -1; last_p = -1; guard = 0;
    while (n_pop - n0 < 4 && guard < 12) begin
      in_valid = (k < 4);
      if (k < 4) begin x = bx[k]; y = by[k]; end
      cycle();
      if (last_acc) k++;
      if (last_pop) begin
        if (first_p < 0) first_p = pop_t;
        last_p = pop_t;
      end
      guard++;
    end
    in_valid = 1'b0;
    chk("t4_results", 66'(n_pop - n0), 66'(4));
    chk("t4_spacing", 66'(last_p - first_p), 66'(3));

    // streaming at full rate
    in_valid = 1'b1; out_ready = 1'b1; chk_lat = 1'b1; n0 = n_pop; acc = 0;
    for (int i = 0; i < 100; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      cycle();
      if (last_acc) acc++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 5) begin cycle(); guard++; end
    chk_lat = 1'b0;
    chk("t5_accepts", 66'(acc), 66'(100));
    chk("t5_results", 66'(n_pop - n0), 66'(100));

    // random traffic with random stalls
    acc = 0; guard = 0; in_valid = 1'b0; last_acc = 1'b0;
    while (acc < 10000 && guard < 60000) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 9) < 7);
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) x = ~y;
        c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (last_acc) acc++;
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1; guard = 0;
    while (q.size() > 0 && guard < 10) begin cycle(); guard++; end
    chk("t6_accepts", 66'(acc), 66'(10000));
    chk("t6_drained", 66'(q.size()), 66'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
